// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundles the EXE/MEM data-access signals and the 16-bit async SRAM pins.
// The master side is the pipeline plus the SRAM device; the slave side is the controller.
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   mem_r_en;
  logic                   mem_w_en;
  logic [31:0]            alu_result;
  logic [31:0]            val_rm;
  logic                   ready;
  logic [31:0]            rdata;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic                   sram_dq_oe;
  logic [15:0]            sram_dq_in;
  logic                   sram_we_n;
  logic                   sram_oe_n;

  modport master (
    output mem_r_en, mem_w_en, alu_result, val_rm, sram_dq_in,
    input  ready, rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_result, val_rm, sram_dq_in,
    output ready, rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Splits each 32-bit load/store into two 16-bit async SRAM accesses (low half, then high half),
// freezing the pipeline through ready until the access completes. WAIT_CYCLES must be 1..15.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  mem_stage_sram_ctrl_if.slave bus
);

  localparam int ADDR_W = SRAM_ADDR_W - 1;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic req;
  logic phase_last;

  assign req        = bus.mem_r_en | bus.mem_w_en;
  assign phase_last = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Store wins when both enables are set; the half-word index is the word offset.
          is_wr_d = bus.mem_w_en;
          addr_d  = ADDR_W'((bus.alu_result - ADDR_BASE) >> 2);
          wdata_d = bus.val_rm;
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_last) begin
          if (!is_wr_q) rdata_d[15:0] = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          if (!is_wr_q) rdata_d[31:16] = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the data registers are few and small, so they are reset along with control state;
  // a reset mid-access therefore leaves no stale word visible on rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins decode only registered state, so input changes never reach the device mid-access.
  logic                   ready_c;
  logic [SRAM_ADDR_W-1:0] sram_addr_c;
  logic [15:0]            sram_dq_out_c;
  logic                   sram_dq_oe_c;
  logic                   sram_we_n_c;
  logic                   sram_oe_n_c;
  logic                   hi_half;

  assign hi_half = (state_q == S_HIGH);

  always_comb begin
    ready_c       = 1'b0;
    sram_addr_c   = '0;
    sram_dq_out_c = '0;
    sram_dq_oe_c  = 1'b0;
    sram_we_n_c   = 1'b1;
    sram_oe_n_c   = 1'b1;

    case (state_q)
      S_IDLE: ready_c = !req;
      S_LOW, S_HIGH: begin
        sram_addr_c   = {addr_q, hi_half};
        sram_dq_out_c = hi_half ? wdata_q[31:16] : wdata_q[15:0];
        if (is_wr_q) begin
          sram_dq_oe_c = 1'b1;
          // Releasing we_n on the phase's last cycle holds address/data past the strobe.
          sram_we_n_c  = phase_last;
        end else begin
          sram_oe_n_c  = 1'b0;
        end
      end
      S_DONE:  ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  assign bus.ready       = ready_c;
  assign bus.rdata       = rdata_q;
  assign bus.sram_addr   = sram_addr_c;
  assign bus.sram_dq_out = sram_dq_out_c;
  assign bus.sram_dq_oe  = sram_dq_oe_c;
  assign bus.sram_we_n   = sram_we_n_c;
  assign bus.sram_oe_n   = sram_oe_n_c;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: an SRAM device model, a transaction-level expected model
// compared every cycle, and directed accesses with hand-computed results.
module tb_mem_stage_sram_ctrl;

  localparam logic [31:0] ADDR_BASE   = 32'd1024;
  localparam int          SRAM_ADDR_W = 18;
  localparam int          WAIT_CYCLES = 1;
  localparam int          PH          = WAIT_CYCLES + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(SRAM_ADDR_W)) bus ();

  mem_stage_sram_ctrl #(
    .ADDR_BASE  (ADDR_BASE),
    .SRAM_ADDR_W(SRAM_ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous SRAM device: writes land while we_n is low, reads are combinational.
  logic [15:0] sram_mem [0:(1<<SRAM_ADDR_W)-1];
  initial for (int i = 0; i < (1 << SRAM_ADDR_W); i++) sram_mem[i] = 16'h0;
  always @(posedge clk) if (!bus.sram_we_n && bus.sram_dq_oe) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
  assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0 : sram_mem[bus.sram_addr];

  // Expected model: an access accepted in cycle t occupies the next 2*PH cycles, then one done cycle.
  logic [31:0] exp_mem [int unsigned];
  bit          m_active;
  int          m_k;
  bit          m_wr;
  logic [16:0] m_word;
  logic [31:0] m_data;
  logic [31:0] m_rdata;

  task automatic check_idle_pins(input string tag);
    check({tag, "_addr"}, 32'(bus.sram_addr), 32'h0);
    check({tag, "_dq_out"}, 32'(bus.sram_dq_out), 32'h0);
    check({tag, "_dq_oe"}, 32'(bus.sram_dq_oe), 32'h0);
    check({tag, "_we_n"}, 32'(bus.sram_we_n), 32'h1);
    check({tag, "_oe_n"}, 32'(bus.sram_oe_n), 32'h1);
  endtask

  always @(negedge clk) begin
    logic        req;
    logic [31:0] off;
    int          h, j;
    req = bus.mem_r_en | bus.mem_w_en;
    if (!rst) begin
      m_active = 0;
      m_k      = 0;
      m_rdata  = 32'h0;
      check("rst_ready", 32'(bus.ready), 32'(!req));
      check("rst_rdata", bus.rdata, 32'h0);
      check_idle_pins("rst");
    end else if (!m_active) begin
      check("idle_ready", 32'(bus.ready), 32'(!req));
      check("idle_rdata", bus.rdata, m_rdata);
      check_idle_pins("idle");
      if (req) begin
        off      = bus.alu_result - ADDR_BASE;
        m_word   = off[18:2];
        m_wr     = bus.mem_w_en;
        m_data   = bus.val_rm;
        m_active = 1;
        m_k      = 1;
      end
    end else if (m_k <= 2 * PH) begin
      h = (m_k - 1) / PH;
      j = (m_k - 1) % PH;
      check("acc_ready", 32'(bus.ready), 32'h0);
      check("acc_addr", 32'(bus.sram_addr), 32'(m_word) * 2 + 32'(h));
      check("acc_dq_out", 32'(bus.sram_dq_out), h == 1 ? 32'(m_data[31:16]) : 32'(m_data[15:0]));
      check("acc_dq_oe", 32'(bus.sram_dq_oe), 32'(m_wr));
      check("acc_we_n", 32'(bus.sram_we_n), (m_wr && j < WAIT_CYCLES) ? 32'h0 : 32'h1);
      check("acc_oe_n", 32'(bus.sram_oe_n), 32'(m_wr));
      m_k++;
    end else begin
      if (m_wr) exp_mem[int'(m_word)] = m_data;
      else m_rdata = exp_mem.exists(int'(m_word)) ? exp_mem[int'(m_word)] : 32'h0;
      check("done_ready", 32'(bus.ready), 32'h1);
      check("done_rdata", bus.rdata, m_rdata);
      check_idle_pins("done");
      m_active = 0;
    end
  end

  // Per-access observations collected by the driver for the literal checks.
  int          n_ready_low, n_we_low, n_oe_low, n_dq_oe;
  logic [33:0] wr_q[$];
  logic [17:0] rd_addr_q[$];

  // Called half a cycle after a rising edge; returns the same way once the access has retired.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit done;
    bus.mem_r_en   = r;
    bus.mem_w_en   = w;
    bus.alu_result = a;
    bus.val_rm     = d;
    n_ready_low = 0; n_we_low = 0; n_oe_low = 0; n_dq_oe = 0;
    wr_q.delete();
    rd_addr_q.delete();
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) done = 1;
      else n_ready_low++;
      if (!bus.sram_we_n) begin
        n_we_low++;
        wr_q.push_back({bus.sram_addr, bus.sram_dq_out});
      end
      if (!bus.sram_oe_n) begin
        n_oe_low++;
        rd_addr_q.push_back(bus.sram_addr);
      end
      if (bus.sram_dq_oe) n_dq_oe++;
    end
    if (!done) check("access_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.mem_r_en   = 1'b0;
    bus.mem_w_en   = 1'b0;
    bus.alu_result = 32'h0;
    bus.val_rm     = 32'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Idle with no request.
    repeat (10) @(posedge clk);
    #1;
    check("idle10_ready", 32'(bus.ready), 32'h1);
    check("idle10_we_n", 32'(bus.sram_we_n), 32'h1);
    check("idle10_oe_n", 32'(bus.sram_oe_n), 32'h1);
    check("idle10_dq_oe", 32'(bus.sram_dq_oe), 32'h0);
    check("idle10_rdata", bus.rdata, 32'h0);

    // Store 0xDEADBEEF to byte 1028 -> SRAM half-words 2 and 3.
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check("st1_ready_low", 32'(n_ready_low), 32'd5);
    check("st1_we_low", 32'(n_we_low), 32'd2);
    check("st1_dq_oe", 32'(n_dq_oe), 32'd4);
    check("st1_wr_count", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("st1_lo", 32'(wr_q[0]), 32'h0002BEEF);
      check("st1_hi", 32'(wr_q[1]), 32'h0003DEAD);
    end

    // Load it back.
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    check("ld1_oe_low", 32'(n_oe_low), 32'd4);
    check("ld1_ready_low", 32'(n_ready_low), 32'd5);
    check("ld1_we_low", 32'(n_we_low), 32'd0);
    check("ld1_first_addr", rd_addr_q.size() > 0 ? 32'(rd_addr_q[0]) : 32'hFFFFFFFF, 32'h2);
    check("ld1_rdata", bus.rdata, 32'hDEADBEEF);

    // A store does not disturb rdata.
    do_access(1'b0, 1'b1, 32'd1032, 32'h0BADF00D);
    check("st2_rdata_kept", bus.rdata, 32'hDEADBEEF);

    // Back-to-back load then store, no idle gap.
    do_access(1'b1, 1'b0, 32'd1032, 32'h0);
    check("b2b_ld_rdata", bus.rdata, 32'h0BADF00D);
    do_access(1'b0, 1'b1, 32'd1036, 32'hCAFE0001);
    check("b2b_st_we_low", 32'(n_we_low), 32'd2);
    check("b2b_st_ready_low", 32'(n_ready_low), 32'd5);
    check("b2b_st_rdata", bus.rdata, 32'h0BADF00D);

    // Both enables: the store wins and rdata is unchanged.
    do_access(1'b1, 1'b1, 32'd1040, 32'hA5A55A5A);
    check("both_we_low", 32'(n_we_low), 32'd2);
    check("both_oe_low", 32'(n_oe_low), 32'd0);
    check("both_rdata", bus.rdata, 32'h0BADF00D);
    do_access(1'b1, 1'b0, 32'd1040, 32'h0);
    check("both_readback", bus.rdata, 32'hA5A55A5A);

    // Address below the base wraps to the top of the SRAM.
    do_access(1'b0, 1'b1, 32'd1020, 32'h12345678);
    if (wr_q.size() == 2) begin
      check("wrap_lo", 32'(wr_q[0]), {14'h0, 18'h3FFFE} << 16 | 32'h5678);
      check("wrap_hi", 32'(wr_q[1]), {14'h0, 18'h3FFFF} << 16 | 32'h1234);
    end else begin
      check("wrap_wr_count", 32'(wr_q.size()), 32'd2);
    end
    do_access(1'b1, 1'b0, 32'd1020, 32'h0);
    check("wrap_readback", bus.rdata, 32'h12345678);

    // Reset in the HIGH phase of a store to byte 2048 (word 256 -> half-words 0x200/0x201).
    bus.mem_w_en   = 1'b1;
    bus.alu_result = 32'd2048;
    bus.val_rm     = 32'h11112222;
    repeat (3) @(posedge clk);
    #2;
    check("mid_high_addr", 32'(bus.sram_addr), 32'h201);
    check("mid_high_we_n", 32'(bus.sram_we_n), 32'h0);
    rst = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    check("rstmid_we_n", 32'(bus.sram_we_n), 32'h1);
    check("rstmid_dq_oe", 32'(bus.sram_dq_oe), 32'h0);
    check("rstmid_addr", 32'(bus.sram_addr), 32'h0);
    check("rstmid_ready", 32'(bus.ready), 32'h1);
    check("rstmid_rdata", bus.rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 32'(bus.ready), 32'h1);
    check("post_rst_rdata", bus.rdata, 32'h0);
    check("post_rst_we_n", 32'(bus.sram_we_n), 32'h1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
